ps2_receiver: RTL and testbench



---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_receiver_if.sv | 32 +++
 rtl/ps2_line_filter.sv | 60 ++++++
 rtl/ps2_receiver.sv | 162 ++++++++++++++++
 tb/tb_ps2_receiver.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and frame FSM encoding for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] KEY_LEFT  = 8'h1C;
  localparam logic [7:0] KEY_RIGHT = 8'h23;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StData   = 2'd1,
    StParity = 2'd2,
    StStop   = 2'd3
  } ps2_state_e;

  // 1 when the data byte plus its parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_receiver_if.sv
// Bundles the raw PS/2 lines and the decoded key outputs of ps2_receiver.
interface ps2_receiver_if;

  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keyboard;
  logic       valid;
  logic       key_release;  // 'release' is a reserved word in SystemVerilog
  logic       extended;
  logic       frame_err;

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output keyboard,
    output valid,
    output key_release,
    output extended,
    output frame_err
  );

  modport master (
    output ps2_clk,
    output ps2_data,
    input  keyboard,
    input  valid,
    input  key_release,
    input  extended,
    input  frame_err
  );

endinterface

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer plus saturating-count deglitcher for one open-collector line.
// o_fall pulses for one cycle in the cycle the filtered level drops to 0.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk2,
  input  logic rst,
  input  logic i_line,
  output logic o_level,
  output logic o_fall
);

  localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic            r_fall;
  logic [CntW-1:0] r_cnt;

  logic            w_level_nxt;
  logic            w_fall_nxt;
  logic [CntW-1:0] w_cnt_nxt;

  // Count consecutive samples that disagree with the filtered level; any agreeing
  // sample restarts the count, so short glitches never reach the threshold.
  always_comb begin
    w_level_nxt = r_level;
    w_fall_nxt  = 1'b0;
    w_cnt_nxt   = '0;
    if (r_sync2 != r_level) begin
      if (r_cnt == CntW'(FILTER_LEN - 1)) begin
        w_level_nxt = r_sync2;
        w_fall_nxt  = ~r_sync2;
      end else begin
        w_cnt_nxt = r_cnt + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_line;
      r_sync2 <= r_sync1;
      r_level <= w_level_nxt;
      r_fall  <= w_fall_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: frames 11-bit packets, checks parity and decodes
// E0/F0 prefixes into one valid or release pulse per key code.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic              clk2,
  input  logic              rst,
  ps2_receiver_if.slave     bus
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic w_clk_level;
  logic w_clk_fall;
  logic w_strobe;
  logic w_timeout;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk2   (clk2),
    .rst    (rst),
    .i_line (bus.ps2_clk),
    .o_level(w_clk_level),
    .o_fall (w_clk_fall)
  );

  // Data needs no deglitching: it is stable well before the filtered clock edge.
  logic r_data_s1;
  logic r_data_s2;

  ps2_state_e      r_state,     w_state_nxt;
  logic [2:0]      r_bit_cnt,   w_bit_cnt_nxt;
  logic [7:0]      r_shift,     w_shift_nxt;
  logic            r_parity_ok, w_parity_ok_nxt;
  logic [TmoW-1:0] r_tmo_cnt,   w_tmo_cnt_nxt;
  logic            r_brk_pend,  w_brk_pend_nxt;
  logic            r_ext_pend,  w_ext_pend_nxt;
  logic [7:0]      r_keyboard,  w_keyboard_nxt;
  logic            r_extended,  w_extended_nxt;
  logic            r_valid,     w_valid_nxt;
  logic            r_release,   w_release_nxt;
  logic            r_frame_err, w_frame_err_nxt;

  assign w_strobe  = w_clk_fall & ~w_clk_level;
  assign w_timeout = (r_state != StIdle) && (r_tmo_cnt == TmoW'(TIMEOUT_CYCLES));

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_parity_ok_nxt = r_parity_ok;
    w_brk_pend_nxt  = r_brk_pend;
    w_ext_pend_nxt  = r_ext_pend;
    w_keyboard_nxt  = r_keyboard;
    w_extended_nxt  = r_extended;
    w_valid_nxt     = 1'b0;
    w_release_nxt   = 1'b0;
    w_frame_err_nxt = 1'b0;

    if (w_strobe || r_state == StIdle || w_timeout) begin
      w_tmo_cnt_nxt = '0;
    end else begin
      w_tmo_cnt_nxt = r_tmo_cnt + TmoW'(1);
    end

    if (w_strobe) begin
      unique case (r_state)
        StIdle: begin
          if (!r_data_s2) begin
            w_state_nxt   = StData;
            w_bit_cnt_nxt = 3'd0;
          end
        end
        StData: begin
          w_shift_nxt = {r_data_s2, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = StParity;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end
        StParity: begin
          w_parity_ok_nxt = odd_parity_ok(r_shift, r_data_s2);
          w_state_nxt     = StStop;
        end
        StStop: begin
          w_state_nxt = StIdle;
          if (r_data_s2 && r_parity_ok) begin
            if (r_shift == PS2_BREAK) begin
              w_brk_pend_nxt = 1'b1;
            end else if (r_shift == PS2_EXT) begin
              w_ext_pend_nxt = 1'b1;
            end else begin
              w_keyboard_nxt = r_shift;
              w_extended_nxt = r_ext_pend;
              w_release_nxt  = r_brk_pend;
              w_valid_nxt    = ~r_brk_pend;
              w_brk_pend_nxt = 1'b0;
              w_ext_pend_nxt = 1'b0;
            end
          end else begin
            // Dropping the prefixes keeps a corrupted break from becoming a make.
            w_frame_err_nxt = 1'b1;
            w_brk_pend_nxt  = 1'b0;
            w_ext_pend_nxt  = 1'b0;
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end else if (w_timeout) begin
      w_state_nxt     = StIdle;
      w_frame_err_nxt = 1'b1;
      w_brk_pend_nxt  = 1'b0;
      w_ext_pend_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      r_data_s1   <= 1'b1;
      r_data_s2   <= 1'b1;
      r_state     <= StIdle;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_parity_ok <= 1'b0;
      r_tmo_cnt   <= '0;
      r_brk_pend  <= 1'b0;
      r_ext_pend  <= 1'b0;
      r_keyboard  <= '0;
      r_extended  <= 1'b0;
      r_valid     <= 1'b0;
      r_release   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_data_s1   <= bus.ps2_data;
      r_data_s2   <= r_data_s1;
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_parity_ok <= w_parity_ok_nxt;
      r_tmo_cnt   <= w_tmo_cnt_nxt;
      r_brk_pend  <= w_brk_pend_nxt;
      r_ext_pend  <= w_ext_pend_nxt;
      r_keyboard  <= w_keyboard_nxt;
      r_extended  <= w_extended_nxt;
      r_valid     <= w_valid_nxt;
      r_release   <= w_release_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  assign bus.keyboard    = r_keyboard;
  assign bus.extended    = r_extended;
  assign bus.valid       = r_valid;
  assign bus.key_release = r_release;
  assign bus.frame_err   = r_frame_err;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver; the PS/2 bus clock is scaled to 80 clk2 cycles per bit.
module tb_ps2_receiver;
  import ps2_pkg::*;

  localparam int unsigned FiltLen = 8;
  localparam int unsigned TmoCyc  = 400;
  localparam int          Half    = 40;

  logic clk2 = 1'b0;
  logic rst  = 1'b1;

  ps2_receiver_if bus ();

  ps2_receiver #(
    .FILTER_LEN    (FiltLen),
    .TIMEOUT_CYCLES(TmoCyc)
  ) dut (
    .clk2(clk2),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk2 = ~clk2;

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse monitor: counts cycles each pulse is high, sampled on the inactive edge.
  int n_valid   = 0;
  int n_rel     = 0;
  int n_err     = 0;
  int n_overlap = 0;

  always @(negedge clk2) begin
    n_valid = n_valid + int'(bus.valid);
    n_rel   = n_rel + int'(bus.key_release);
    n_err   = n_err + int'(bus.frame_err);
    if ((int'(bus.valid) + int'(bus.key_release) + int'(bus.frame_err)) > 1)
      n_overlap = n_overlap + 1;
  end

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    int         exp_valid;
    int         exp_rel;
    int         exp_err;
    logic [7:0] exp_kb;
    bit         exp_ext;
  } vec_t;

  vec_t vecs[14];

  task automatic tick(input int n);
    repeat (n) @(posedge clk2);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] code, input bit bad_par);
    logic par;
    par = ~(^code) ^ bad_par;
    return {1'b1, par, code, 1'b0};
  endfunction

  // Drive the first nbits of a frame, LSB (start bit) first; optional low glitch
  // in the high phase of bit 4.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = bits[i];
      if (glitch && i == 4) begin
        tick(Half / 2);
        bus.ps2_clk = 1'b0;
        tick(3);
        bus.ps2_clk = 1'b1;
        tick(Half / 2 - 3);
      end else begin
        tick(Half);
      end
      bus.ps2_clk = 1'b0;
      tick(Half);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic frame_check(input string tag, input logic [7:0] code, input bit bad_par,
                             input bit glitch, input int ev, input int er, input int ee,
                             input logic [7:0] kb, input bit ext);
    int v0, r0, e0;
    v0 = n_valid;
    r0 = n_rel;
    e0 = n_err;
    send_bits(make_frame(code, bad_par), 11, glitch);
    tick(60);
    check({tag, ".valid"},    n_valid - v0, ev);
    check({tag, ".release"},  n_rel - r0, er);
    check({tag, ".frame_err"}, n_err - e0, ee);
    check({tag, ".keyboard"}, bus.keyboard, kb);
    check({tag, ".extended"}, bus.extended, ext);
  endtask

  initial begin
    int v0, r0, e0;
    vecs[0]  = '{KEY_LEFT,  1'b0, 1, 0, 0, KEY_LEFT,  1'b0};
    vecs[1]  = '{PS2_BREAK, 1'b0, 0, 0, 0, KEY_LEFT,  1'b0};
    vecs[2]  = '{KEY_RIGHT, 1'b0, 0, 1, 0, KEY_RIGHT, 1'b0};
    vecs[3]  = '{KEY_RIGHT, 1'b0, 1, 0, 0, KEY_RIGHT, 1'b0};
    vecs[4]  = '{PS2_EXT,   1'b0, 0, 0, 0, KEY_RIGHT, 1'b0};
    vecs[5]  = '{PS2_BREAK, 1'b0, 0, 0, 0, KEY_RIGHT, 1'b0};
    vecs[6]  = '{KEY_LEFT,  1'b0, 0, 1, 0, KEY_LEFT,  1'b1};
    vecs[7]  = '{KEY_LEFT,  1'b1, 0, 0, 1, KEY_LEFT,  1'b1};
    vecs[8]  = '{KEY_RIGHT, 1'b0, 1, 0, 0, KEY_RIGHT, 1'b0};
    vecs[9]  = '{PS2_BREAK, 1'b0, 0, 0, 0, KEY_RIGHT, 1'b0};
    vecs[10] = '{KEY_LEFT,  1'b1, 0, 0, 1, KEY_RIGHT, 1'b0};
    vecs[11] = '{KEY_LEFT,  1'b0, 1, 0, 0, KEY_LEFT,  1'b0};
    vecs[12] = '{PS2_EXT,   1'b0, 0, 0, 0, KEY_LEFT,  1'b0};
    vecs[13] = '{KEY_RIGHT, 1'b0, 1, 0, 0, KEY_RIGHT, 1'b1};

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst = 1'b1;
    tick(5);
    check("reset.keyboard",  bus.keyboard, 8'h00);
    check("reset.valid",     bus.valid, 1'b0);
    check("reset.release",   bus.key_release, 1'b0);
    check("reset.extended",  bus.extended, 1'b0);
    check("reset.frame_err", bus.frame_err, 1'b0);
    rst = 1'b0;
    tick(20);

    for (int i = 0; i < 14; i++) begin
      frame_check($sformatf("vec%0d", i), vecs[i].code, vecs[i].bad_par, 1'b0,
                  vecs[i].exp_valid, vecs[i].exp_rel, vecs[i].exp_err,
                  vecs[i].exp_kb, vecs[i].exp_ext);
    end

    // Short low glitches while idle with data low would look like a start bit.
    bus.ps2_data = 1'b0;
    for (int g = 0; g < 3; g++) begin
      bus.ps2_clk = 1'b0;
      tick(3);
      bus.ps2_clk = 1'b1;
      tick(20);
    end
    bus.ps2_data = 1'b1;
    tick(Half);
    frame_check("glitch", KEY_LEFT, 1'b0, 1'b1, 1, 0, 0, KEY_LEFT, 1'b0);

    // Abandoned frame after 4 data bits must time out.
    v0 = n_valid;
    e0 = n_err;
    send_bits(make_frame(KEY_RIGHT, 1'b0), 5, 1'b0);
    tick(TmoCyc + 20);
    check("timeout.frame_err", n_err - e0, 1);
    check("timeout.valid",     n_valid - v0, 0);
    frame_check("after_tmo", KEY_RIGHT, 1'b0, 1'b0, 1, 0, 0, KEY_RIGHT, 1'b0);

    // Reset mid-frame with a break pending: outputs clear and the break is forgotten.
    frame_check("pre_rst_brk", PS2_BREAK, 1'b0, 1'b0, 0, 0, 0, KEY_RIGHT, 1'b0);
    v0 = n_valid;
    r0 = n_rel;
    e0 = n_err;
    send_bits(make_frame(KEY_LEFT, 1'b0), 4, 1'b0);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2 * Half);
    check("midrst.keyboard", bus.keyboard, 8'h00);
    check("midrst.extended", bus.extended, 1'b0);
    check("midrst.pulses",   (n_valid - v0) + (n_rel - r0) + (n_err - e0), 0);
    frame_check("after_rst", KEY_RIGHT, 1'b0, 1'b0, 1, 0, 0, KEY_RIGHT, 1'b0);

    check("pulse_overlap", n_overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
